// File: rtl/vga_pixel_scanner.sv
// VGA timing source: scan counters, a frame strobe, a sync/blank delay line
// that tracks the RGB mux latency, and a DAC output stage with RGB332 expansion.
module vga_pixel_scanner #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MUX_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  input  logic [7:0]  RGBIn,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        vgaHS,
  output logic        vgaVS,
  output logic        vgaBlankN
);

  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_PRE_SOF = 11'(V_ACTIVE - 1);
  localparam int          DL_TOP    = MUX_LATENCY - 1;

  // 3-bit channel to 8 bits by bit replication, so full scale maps to 8'hFF
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // 2-bit channel to 8 bits by bit replication
  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [10:0] hCnt;
  logic [10:0] vCnt;
  logic        sof;
  logic        hWrap;
  logic        vWrap;

  assign hWrap = (hCnt == H_LAST);
  assign vWrap = (vCnt == V_LAST);

  // Stage p0: scan counters and the frame strobe, which lines up with pixelX/pixelY
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hCnt <= '0;
      vCnt <= '0;
      sof  <= 1'b0;
    end else begin
      hCnt <= hWrap ? '0 : hCnt + 11'd1;
      if (hWrap) begin
        vCnt <= vWrap ? '0 : vCnt + 11'd1;
      end
      sof <= hWrap && (vCnt == V_PRE_SOF);
    end
  end

  assign pixelX       = hCnt;
  assign pixelY       = vCnt;
  assign startOfFrame = sof;

  logic vld_p0;
  logic hsN_p0;
  logic vsN_p0;

  assign vld_p0 = (hCnt < H_VIS) && (vCnt < V_VIS);
  assign hsN_p0 = !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
  assign vsN_p0 = !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));

  logic [DL_TOP:0] vld_dl;
  logic [DL_TOP:0] hsN_dl;
  logic [DL_TOP:0] vsN_dl;

  // Stages p1..pN: flags ride a shift register as deep as the RGB mux pipeline
  always_ff @(posedge clk) begin
    if (!resetN) begin
      vld_dl <= '0;
      hsN_dl <= '1;
      vsN_dl <= '1;
    end else begin
      vld_dl <= MUX_LATENCY'({vld_dl, vld_p0});
      hsN_dl <= MUX_LATENCY'({hsN_dl, hsN_p0});
      vsN_dl <= MUX_LATENCY'({vsN_dl, vsN_p0});
    end
  end

  // Output stage: capture the mux pixel beside its delayed flags; blank forces black
  always_ff @(posedge clk) begin
    if (!resetN) begin
      vgaR      <= '0;
      vgaG      <= '0;
      vgaB      <= '0;
      vgaHS     <= 1'b1;
      vgaVS     <= 1'b1;
      vgaBlankN <= 1'b0;
    end else begin
      vgaHS     <= hsN_dl[DL_TOP];
      vgaVS     <= vsN_dl[DL_TOP];
      vgaBlankN <= vld_dl[DL_TOP];
      if (vld_dl[DL_TOP]) begin
        vgaR <= expand3(RGBIn[7:5]);
        vgaG <= expand3(RGBIn[4:2]);
        vgaB <= expand2(RGBIn[1:0]);
      end else begin
        vgaR <= '0;
        vgaG <= '0;
        vgaB <= '0;
      end
    end
  end

endmodule
